// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared constants and types for the scoreboarded register file.
//   XLEN_D / NREG_D / NRD_D : default data width, register count, read ports
//   reg_addr_t / reg_data_t : address and data types at the default geometry
package regfile_pkg;

  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;
  localparam int NRD_D  = 2;

  typedef logic [$clog2(NREG_D)-1:0] reg_addr_t;
  typedef logic [XLEN_D-1:0]         reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard -- per-register "pending write" bits plus a running count.
//   clk_i, rst_i     : clock, async active-high reset
//   set_en_i/addr_i  : reservation request (alloc) for a destination register
//   clr_en_i/addr_i  : completed write, releases the reservation
//   busy_o           : busy vector, bit 0 is always 0
//   busy_cnt_o       : number of busy registers (kept as a register)
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int AW   = $clog2(NREG),
  parameter int CW   = $clog2(NREG) + 1
)(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            set_en_i,
  input  logic [AW-1:0]   set_addr_i,
  input  logic            clr_en_i,
  input  logic [AW-1:0]   clr_addr_i,
  output logic [NREG-1:0] busy_o,
  output logic [CW-1:0]   busy_cnt_o
);

  logic [NREG-1:0] busy_d, busy_q;
  logic [CW-1:0]   cnt_d, cnt_q;
  logic            set_hit_s, clr_hit_s, inc_s, dec_s;

  // Next busy vector and count adjustment.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    set_hit_s = set_en_i && (set_addr_i != {AW{1'b0}});
    // A same-address alloc overrides the clear from the write.
    clr_hit_s = clr_en_i && (clr_addr_i != {AW{1'b0}}) &&
                !(set_hit_s && (set_addr_i == clr_addr_i));
    // Count only real transitions: setting an already-busy bit or
    // clearing an idle one leaves the population unchanged.
    inc_s     = set_hit_s && !busy_q[set_addr_i];
    dec_s     = clr_hit_s && busy_q[clr_addr_i];
    if (clr_hit_s) begin
      busy_d[clr_addr_i] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (set_hit_s) begin
      busy_d[set_addr_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
    case ({inc_s, dec_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Busy state and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= {NREG{1'b0}};
      cnt_q  <= {CW{1'b0}};
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- register file with a destination-reservation scoreboard.
//   clk, rst            : clock, async active-high reset
//   rd_addr/rd_data     : NRD combinational read ports
//   rd_busy             : busy bit of the register each port reads
//   wr_en/addr/data     : write port, also releases the reservation
//   alloc_en/addr/ok    : reserve a destination register
//   busy_cnt, dbg_data  : reserved-register count, mirror of r[DBG_IDX]
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write
// to matching read ports (data and a cleared busy flag).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN    = XLEN_D,
  parameter int NREG    = NREG_D,
  parameter int NRD     = NRD_D,
  parameter int DBG_IDX = 17,
  localparam int AW     = $clog2(NREG),
  localparam int CW     = $clog2(NREG) + 1
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD-1:0][AW-1:0]  rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [XLEN-1:0]         wr_data,
  input  logic                    alloc_en,
  input  logic [AW-1:0]           alloc_addr,
  output logic                    alloc_ok,
  output logic [CW-1:0]           busy_cnt,
  output logic [XLEN-1:0]         dbg_data
);

  logic [XLEN-1:0] r_q [NREG];
  logic [NREG-1:0] busy_s;
  logic            wr_hit_s;

  assign wr_hit_s = wr_en && (wr_addr != {AW{1'b0}});

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .CW   (CW)
  ) u_sb (
    .clk_i      (clk),
    .rst_i      (rst),
    .set_en_i   (alloc_en),
    .set_addr_i (alloc_addr),
    .clr_en_i   (wr_en),
    .clr_addr_i (wr_addr),
    .busy_o     (busy_s),
    .busy_cnt_o (busy_cnt)
  );

  // Data array; entry 0 is never written so it reads as zero forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_q[i] <= {XLEN{1'b0}};
      end
    end else if (wr_hit_s) begin
      r_q[wr_addr] <= wr_data;
    end
  end

  // Combinational read ports, optionally with write-through forwarding.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_data[p] = r_q[rd_addr[p]];
      rd_busy[p] = busy_s[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit_s && (wr_addr == rd_addr[p])) begin
        rd_data[p] = wr_data;
        rd_busy[p] = 1'b0;
      end else begin
        rd_busy[p] = rd_busy[p];
      end
`endif
    end
  end

  // busy[0] is tied low, so allocs to r0 are always accepted (and ignored).
  assign alloc_ok = alloc_en & ~busy_s[alloc_addr];
  assign dbg_data = r_q[DBG_IDX];

endmodule
